prco_pipe_ctrl: RTL and testbench
=================================

// Module: prco_pipe_ctrl
// PURPOSE
//   Multi-cycle sequencer for the PRCO core. It drives the chip-enables for fetch, decoder, ALU, RAM,
//   register write-back and UART write, one instruction at a time. It consumes the decoder's
//   dependency flags (reg_we/req_alu/req_ram/req_ram_we/new_uart1_data/halt) and its ce/fetch strobes.
//   It owns PC-increment timing, halt handling and the retired-instruction count.
// PARAMETERS
//   MEM_TIMEOUT  15  max cycles in MEM waiting for i_mem_ready before fault-halt (1..255)
//   CNT_W        16  width of q_retired counter
// PORTS
//   i_clk          in   1      core clock; sole clock domain
//   i_reset        in   1      reset, synchronous, active-high
//   i_en           in   1      run enable; sampled in IDLE and on every entry to FETCH
//   i_fetch_done   in   1      instruction word valid at decoder input
//   i_dec_ce       in   1      decoder strobe: decode done, execute required
//   i_dec_fetch    in   1      decoder strobe: no execute (NOP), refetch
//   i_reg_we       in   1      decoder flag: write-back required
//   i_req_ram      in   1      decoder flag: RAM access required
//   i_req_ram_we   in   1      decoder flag: RAM access is a store
//   i_uart_req     in   1      decoder flag: new UART1 data
//   i_halt         in   1      decoder flag: halt (unknown opcode)
//   i_mem_ready    in   1      RAM access complete
//   i_uart_busy    in   1      UART transmitter busy
//   q_fetch_ce     out  1      1-cycle pulse: start fetch
//   q_dec_ce       out  1      1-cycle pulse: decoder ce
//   q_alu_ce       out  1      1-cycle pulse: ALU execute
//   q_mem_ce       out  1      level: RAM access active
//   q_mem_we       out  1      level: RAM store; valid only while q_mem_ce=1
//   q_wb_ce        out  1      1-cycle pulse: register file write
//   q_uart_we      out  1      1-cycle pulse: UART1 write
//   q_pc_inc       out  1      1-cycle pulse: increment PC (one per retired instruction)
//   q_halted       out  1      sticky halt indicator
//   q_fault        out  1      sticky; set when halt was caused by MEM timeout
//   q_state        out  3      current state encoding (debug)
//   q_retired      out  CNT_W  retired-instruction count; wraps to 0
// BEHAVIOUR
//   - All outputs are registered. On i_reset (sync): state=IDLE and every output=0, including the
//     counters and the latched flags. Reset mid-instruction aborts the instruction; no pulses are
//     issued in the reset cycle.
//   - State encoding: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 UART=6 HALT=7.
//   - Each "pulse" output is high only in the first cycle after entering its state.
//   - IDLE:   i_en=1 -> FETCH, asserting q_fetch_ce.
//   - FETCH:  wait for i_fetch_done=1 -> DECODE, asserting q_dec_ce.
//   - DECODE: wait for i_dec_ce or i_dec_fetch. Priority is i_halt > i_dec_fetch > i_dec_ce:
//       halt      -> HALT, with q_halted=1.
//       dec_fetch -> retire the instruction.
//       dec_ce    -> latch reg_we/req_ram/ram_we/uart_req, then go to EXEC with q_alu_ce.
//   - EXEC: exactly 1 cycle. Then go to:
//       req_ram  -> MEM (q_mem_ce=1, q_mem_we=latched ram_we), else
//       uart_req -> UART, else
//       reg_we   -> WB, else
//       retire.
//   - MEM: hold q_mem_ce until i_mem_ready=1.
//       On ready, drop q_mem_ce/q_mem_we the next cycle, then go to WB if reg_we, else retire.
//       The timeout counter starts at 0 on MEM entry and increments each cycle without ready.
//       When it reaches MEM_TIMEOUT, go to HALT with q_fault=1.
//       If ready arrives in the same cycle the counter reaches MEM_TIMEOUT, ready wins.
//   - UART: wait for i_uart_busy=0, then pulse q_uart_we once and retire. No timeout.
//   - WB: pulse q_wb_ce, then retire.
//   - Retire: pulse q_pc_inc, q_retired+=1 (wraps at 2^CNT_W-1 -> 0).
//       i_en=1 -> FETCH with q_fetch_ce in the same cycle; else -> IDLE.
//   - i_en deasserted mid-instruction: the instruction completes; the controller stops at retire.
//   - HALT: absorbing; all ce/pulse outputs stay 0; only i_reset exits.
//   - Best-case latency for an ALU instruction with fetch_done immediate:
//       FETCH -> DECODE -> EXEC -> WB -> FETCH = 4 cycles + decoder strobe delay.
// TESTING
//   1. ADD (reg_we=1, i_fetch_done and i_dec_ce 1 cycle after request)
//      -> q_alu_ce, q_wb_ce, q_pc_inc each pulse once, in order; q_retired=1.
//   2. LW, i_mem_ready 3 cycles after MEM entry
//      -> q_mem_ce high exactly 3 cycles, q_mem_we=0, then q_wb_ce, then q_pc_inc.
//   3. SW with i_mem_ready never asserted
//      -> after 15 cycles in MEM, q_halted=1, q_fault=1, q_state=7; no q_pc_inc.
//   4. WRITE with i_uart_busy=1 for 5 cycles
//      -> q_uart_we pulses once, in the cycle after busy falls; no q_wb_ce.
//   5. i_halt=1 with i_dec_fetch=1 simultaneously
//      -> HALT, q_fault=0; i_reset then gives q_state=0 with all outputs 0.
//   6. CNT_W=4, 16 NOPs (i_dec_fetch), i_en dropped during the 16th
//      -> q_retired wraps to 0; state ends in IDLE.

Source files
------------

// File: rtl/prco_pipe_ctrl_if.sv
// Handshake bundle between the PRCO pipeline sequencer and the rest of the core.
// master: the sequencer (drives the chip-enables and status).
// slave:  the core side (fetch unit, decoder, RAM, UART).
interface prco_pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             i_en;
  logic             i_fetch_done;
  logic             i_dec_ce;
  logic             i_dec_fetch;
  logic             i_reg_we;
  logic             i_req_ram;
  logic             i_req_ram_we;
  logic             i_uart_req;
  logic             i_halt;
  logic             i_mem_ready;
  logic             i_uart_busy;
  logic             q_fetch_ce;
  logic             q_dec_ce;
  logic             q_alu_ce;
  logic             q_mem_ce;
  logic             q_mem_we;
  logic             q_wb_ce;
  logic             q_uart_we;
  logic             q_pc_inc;
  logic             q_halted;
  logic             q_fault;
  logic [2:0]       q_state;
  logic [CNT_W-1:0] q_retired;

  modport master (
    input  i_en, i_fetch_done, i_dec_ce, i_dec_fetch, i_reg_we, i_req_ram,
           i_req_ram_we, i_uart_req, i_halt, i_mem_ready, i_uart_busy,
    output q_fetch_ce, q_dec_ce, q_alu_ce, q_mem_ce, q_mem_we, q_wb_ce,
           q_uart_we, q_pc_inc, q_halted, q_fault, q_state, q_retired
  );

  modport slave (
    output i_en, i_fetch_done, i_dec_ce, i_dec_fetch, i_reg_we, i_req_ram,
           i_req_ram_we, i_uart_req, i_halt, i_mem_ready, i_uart_busy,
    input  q_fetch_ce, q_dec_ce, q_alu_ce, q_mem_ce, q_mem_we, q_wb_ce,
           q_uart_we, q_pc_inc, q_halted, q_fault, q_state, q_retired
  );
endinterface

// File: rtl/prco_pipe_ctrl.sv
// PRCO multi-cycle sequencer: walks one instruction at a time through
// fetch, decode, execute and the optional RAM / UART / write-back phases,
// pulsing the matching chip-enable and counting retired instructions.
// Retirement is not a state of its own: it happens on the transition out of
// DECODE (NOP), EXEC, MEM, UART or WB and chains straight into the next FETCH.
// The bus interface must be instantiated with the same CNT_W as this module.
module prco_pipe_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  prco_pipe_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_UART   = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // Last counter value before the MEM wait gives up (counter starts at 0).
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [7:0] mem_cnt;
  logic       lat_reg_we;
  logic       lat_req_ram;
  logic       lat_ram_we;
  logic       lat_uart_req;
  logic       retire;

  assign bus.q_state = state;

  // Decide whether the current cycle finishes the instruction in flight.
  always_comb begin
    retire = 1'b0;
    case (state)
      S_DECODE: retire = bus.i_dec_fetch & ~bus.i_halt;
      S_EXEC:   retire = ~lat_req_ram & ~lat_uart_req & ~lat_reg_we;
      S_MEM:    retire = bus.i_mem_ready & ~lat_reg_we;
      S_UART:   retire = ~bus.i_uart_busy;
      S_WB:     retire = 1'b1;
      default:  retire = 1'b0;
    endcase
  end

  // Sequencer state, latched decoder flags and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state          <= S_IDLE;
      mem_cnt        <= 8'd0;
      lat_reg_we     <= 1'b0;
      lat_req_ram    <= 1'b0;
      lat_ram_we     <= 1'b0;
      lat_uart_req   <= 1'b0;
      bus.q_fetch_ce <= 1'b0;
      bus.q_dec_ce   <= 1'b0;
      bus.q_alu_ce   <= 1'b0;
      bus.q_mem_ce   <= 1'b0;
      bus.q_mem_we   <= 1'b0;
      bus.q_wb_ce    <= 1'b0;
      bus.q_uart_we  <= 1'b0;
      bus.q_pc_inc   <= 1'b0;
      bus.q_halted   <= 1'b0;
      bus.q_fault    <= 1'b0;
      bus.q_retired  <= '0;
    end else begin
      // Pulses last a single cycle unless re-armed below.
      bus.q_fetch_ce <= 1'b0;
      bus.q_dec_ce   <= 1'b0;
      bus.q_alu_ce   <= 1'b0;
      bus.q_wb_ce    <= 1'b0;
      bus.q_uart_we  <= 1'b0;
      bus.q_pc_inc   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.i_en) begin
            state          <= S_FETCH;
            bus.q_fetch_ce <= 1'b1;
          end
        end
        S_FETCH: begin
          if (bus.i_fetch_done) begin
            state        <= S_DECODE;
            bus.q_dec_ce <= 1'b1;
          end
        end
        S_DECODE: begin
          if (bus.i_halt && (bus.i_dec_ce || bus.i_dec_fetch)) begin
            state        <= S_HALT;
            bus.q_halted <= 1'b1;
          end else if (!bus.i_dec_fetch && bus.i_dec_ce) begin
            lat_reg_we   <= bus.i_reg_we;
            lat_req_ram  <= bus.i_req_ram;
            lat_ram_we   <= bus.i_req_ram_we;
            lat_uart_req <= bus.i_uart_req;
            state        <= S_EXEC;
            bus.q_alu_ce <= 1'b1;
          end
        end
        S_EXEC: begin
          if (lat_req_ram) begin
            state        <= S_MEM;
            mem_cnt      <= 8'd0;
            bus.q_mem_ce <= 1'b1;
            bus.q_mem_we <= lat_ram_we;
          end else if (lat_uart_req) begin
            state <= S_UART;
          end else if (lat_reg_we) begin
            state       <= S_WB;
            bus.q_wb_ce <= 1'b1;
          end
        end
        S_MEM: begin
          // A ready arriving on the timeout cycle still completes the access.
          if (bus.i_mem_ready) begin
            bus.q_mem_ce <= 1'b0;
            bus.q_mem_we <= 1'b0;
            if (lat_reg_we) begin
              state       <= S_WB;
              bus.q_wb_ce <= 1'b1;
            end
          end else if (mem_cnt == TMO_LAST) begin
            state        <= S_HALT;
            bus.q_mem_ce <= 1'b0;
            bus.q_mem_we <= 1'b0;
            bus.q_halted <= 1'b1;
            bus.q_fault  <= 1'b1;
          end else begin
            mem_cnt <= mem_cnt + 8'd1;
          end
        end
        S_UART: begin
          if (!bus.i_uart_busy) begin
            bus.q_uart_we <= 1'b1;
          end
        end
        S_WB: begin
          state <= S_WB;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (retire) begin
        bus.q_pc_inc  <= 1'b1;
        bus.q_retired <= bus.q_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        if (bus.i_en) begin
          state          <= S_FETCH;
          bus.q_fetch_ce <= 1'b1;
        end else begin
          state <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_prco_pipe_ctrl.sv
// Directed bench for prco_pipe_ctrl. A timeline model plans each instruction
// from its phase rules (fetch/decode delays, RAM/UART waits, retire chaining)
// into per-cycle input and expected-output tables; the run loop then checks
// every cycle, and a few hand-computed points pin the timeline.
module tb_prco_pipe_ctrl;

  localparam int NE = 126;
  localparam int MT = 15;
  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC = 3;
  localparam int ST_MEM = 4, ST_WB = 5, ST_UART = 6, ST_HALT = 7;

  typedef struct packed {
    logic rst, en, fetch_done, dec_ce, dec_fetch, reg_we, req_ram, ram_we,
          uart_req, halt, mem_ready, uart_busy;
  } in_t;

  logic clk;
  logic rst;
  prco_pipe_ctrl_if #(.CNT_W(4)) bus ();

  prco_pipe_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  in_t         iv [NE];
  bit          e_fetch [NE], e_dec [NE], e_alu [NE], e_mem [NE], e_mwe [NE];
  bit          e_wb [NE], e_uwe [NE], e_pc [NE];
  bit          ret_evt [NE], halt_evt [NE], fault_evt [NE];
  int          st_evt [NE];
  logic [16:0] exp_v [NE];
  int          o_mem [NE], o_wb [NE], o_uwe [NE], o_pc [NE], o_ret [NE];
  int          o_state [NE], o_halted [NE], o_fault [NE];
  int          checks = 0;
  int          errors = 0;

  task automatic retire_at(input int t);
    e_pc[t]    = 1'b1;
    ret_evt[t] = 1'b1;
    if (iv[t].en) begin
      e_fetch[t] = 1'b1;
      st_evt[t]  = ST_FETCH;
    end else begin
      st_evt[t] = ST_IDLE;
    end
  endtask

  // Plan one instruction whose FETCH begins at edge s; t_end = retire or halt edge.
  task automatic instr(input int s, input int fd, input int dd, input bit nop,
                       input bit hlt, input bit rw, input bit rr, input bit rwe,
                       input bit ur, input int rdy, input int busy, output int t_end);
    int e, m, c;
    e_fetch[s] = 1'b1;
    st_evt[s]  = ST_FETCH;
    iv[s+fd].fetch_done = 1'b1;
    e_dec[s+fd]  = 1'b1;
    st_evt[s+fd] = ST_DECODE;
    e = s + fd + dd;
    if (nop) iv[e].dec_fetch = 1'b1;
    else     iv[e].dec_ce    = 1'b1;
    iv[e].halt = hlt; iv[e].reg_we = rw; iv[e].req_ram = rr;
    iv[e].ram_we = rwe; iv[e].uart_req = ur;
    if (hlt) begin
      st_evt[e] = ST_HALT; halt_evt[e] = 1'b1; t_end = e;
    end else if (nop) begin
      retire_at(e); t_end = e;
    end else begin
      e_alu[e] = 1'b1; st_evt[e] = ST_EXEC; m = e + 1;
      if (rr) begin
        st_evt[m] = ST_MEM;
        c = (rdy == 0) ? m + MT : m + rdy;
        for (int k = m; k < c; k++) begin e_mem[k] = 1'b1; e_mwe[k] = rwe; end
        if (rdy == 0) begin
          st_evt[c] = ST_HALT; halt_evt[c] = 1'b1; fault_evt[c] = 1'b1; t_end = c;
        end else begin
          iv[c].mem_ready = 1'b1;
          if (rw) begin
            e_wb[c] = 1'b1; st_evt[c] = ST_WB; retire_at(c + 1); t_end = c + 1;
          end else begin
            retire_at(c); t_end = c;
          end
        end
      end else if (ur) begin
        st_evt[m] = ST_UART;
        for (int k = m; k <= m + busy; k++) iv[k].uart_busy = 1'b1;
        c = m + busy + 1;
        e_uwe[c] = 1'b1; retire_at(c); t_end = c;
      end else if (rw) begin
        e_wb[m] = 1'b1; st_evt[m] = ST_WB; retire_at(m + 1); t_end = m + 1;
      end else begin
        retire_at(m); t_end = m;
      end
    end
  endtask

  task automatic lit(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int sum(input int a[NE], input int lo, input int hi);
    int s = 0;
    for (int k = lo; k <= hi; k++) s += a[k];
    return s;
  endfunction

  initial begin
    int t, st, ret;
    bit hd, ft;
    logic [16:0] act;

    for (int k = 0; k < NE; k++) begin
      iv[k] = '0; st_evt[k] = -1;
      e_fetch[k] = 0; e_dec[k] = 0; e_alu[k] = 0; e_mem[k] = 0; e_mwe[k] = 0;
      e_wb[k] = 0; e_uwe[k] = 0; e_pc[k] = 0;
      ret_evt[k] = 0; halt_evt[k] = 0; fault_evt[k] = 0;
    end
    for (int k = 0; k < 3; k++) iv[k].rst = 1'b1;
    for (int k = 74; k < 76; k++) iv[k].rst = 1'b1;
    for (int k = 84; k < 86; k++) iv[k].rst = 1'b1;
    for (int k = 3; k <= 73; k++) iv[k].en = 1'b1;
    for (int k = 76; k <= 83; k++) iv[k].en = 1'b1;
    for (int k = 86; k <= 116; k++) iv[k].en = 1'b1;

    // Run A: ADD, LW, UART write, SW ready on timeout edge, ALU no-wb, SW timeout.
    instr(3,  1, 1, 0, 0, 1, 0, 0, 0, 0,  0, t);
    instr(t,  1, 1, 0, 0, 1, 1, 0, 0, 3,  0, t);
    instr(t,  2, 1, 0, 0, 0, 0, 0, 1, 0,  5, t);
    instr(t,  1, 1, 0, 0, 0, 1, 1, 0, MT, 0, t);
    instr(t,  1, 3, 0, 0, 0, 0, 0, 0, 0,  0, t);
    instr(t,  1, 1, 0, 0, 0, 1, 1, 0, 0,  0, t);
    for (int k = t + 1; k <= 73; k += 2) begin
      iv[k].fetch_done = 1'b1; iv[k].dec_ce = 1'b1; iv[k].mem_ready = 1'b1;
    end
    // Run B: halt together with dec_fetch.
    instr(76, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, t);
    // Run C: 16 NOPs, enable dropped during the last one.
    t = 86;
    for (int i = 0; i < 16; i++) instr(t, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, t);

    st = ST_IDLE; ret = 0; hd = 0; ft = 0;
    for (int k = 0; k < NE; k++) begin
      if (iv[k].rst) begin
        st = ST_IDLE; ret = 0; hd = 0; ft = 0;
      end else begin
        if (st_evt[k] >= 0) st = st_evt[k];
        if (ret_evt[k]) ret = (ret + 1) % 16;
        if (halt_evt[k]) hd = 1'b1;
        if (fault_evt[k]) ft = 1'b1;
      end
      exp_v[k] = {e_fetch[k], e_dec[k], e_alu[k], e_mem[k], e_mwe[k], e_wb[k],
                  e_uwe[k], e_pc[k], hd, ft, 3'(st), 4'(ret)};
    end

    for (int k = 0; k < NE; k++) begin
      rst = iv[k].rst;
      bus.i_en = iv[k].en; bus.i_fetch_done = iv[k].fetch_done;
      bus.i_dec_ce = iv[k].dec_ce; bus.i_dec_fetch = iv[k].dec_fetch;
      bus.i_reg_we = iv[k].reg_we; bus.i_req_ram = iv[k].req_ram;
      bus.i_req_ram_we = iv[k].ram_we; bus.i_uart_req = iv[k].uart_req;
      bus.i_halt = iv[k].halt; bus.i_mem_ready = iv[k].mem_ready;
      bus.i_uart_busy = iv[k].uart_busy;
      @(posedge clk);
      #1;
      act = {bus.q_fetch_ce, bus.q_dec_ce, bus.q_alu_ce, bus.q_mem_ce, bus.q_mem_we,
             bus.q_wb_ce, bus.q_uart_we, bus.q_pc_inc, bus.q_halted, bus.q_fault,
             bus.q_state, bus.q_retired};
      o_mem[k] = int'(bus.q_mem_ce); o_wb[k] = int'(bus.q_wb_ce);
      o_uwe[k] = int'(bus.q_uart_we); o_pc[k] = int'(bus.q_pc_inc);
      o_ret[k] = int'(bus.q_retired); o_state[k] = int'(bus.q_state);
      o_halted[k] = int'(bus.q_halted); o_fault[k] = int'(bus.q_fault);
      checks++;
      if (act !== exp_v[k]) begin
        errors++;
        $display("FAIL cycle%0d outputs: got %05h, expected %05h", k, act, exp_v[k]);
      end
    end

    lit("add_wb_state",   o_state[6], 5);
    lit("add_pc_inc",     o_pc[7],    1);
    lit("add_retired",    o_ret[7],   1);
    lit("lw_mem_cycles",  sum(o_mem, 8, 15), 3);
    lit("lw_wb",          o_wb[13],   1);
    lit("lw_retired",     o_ret[14],  2);
    lit("uart_wait",      o_state[23], 6);
    lit("uart_we_at",     o_uwe[24],  1);
    lit("uart_we_once",   sum(o_uwe, 14, 30), 1);
    lit("uart_no_wb",     sum(o_wb, 14, 24), 0);
    lit("sw_edge_mem",    sum(o_mem, 26, 45), 15);
    lit("sw_edge_pc",     o_pc[42],   1);
    lit("sw_to_halted",   o_halted[65], 1);
    lit("sw_to_fault",    o_fault[65],  1);
    lit("sw_to_state",    o_state[65],  7);
    lit("sw_to_mem",      sum(o_mem, 48, 73), 15);
    lit("sw_to_no_pc",    sum(o_pc, 48, 73), 0);
    lit("sw_to_retired",  o_ret[73],  5);
    lit("halt_halted",    o_halted[78], 1);
    lit("halt_no_fault",  o_fault[78],  0);
    lit("reset_state",    o_state[85],  0);
    lit("reset_halted",   o_halted[85], 0);
    lit("nop15_retired",  o_ret[116], 15);
    lit("nop16_wrap",     o_ret[118], 0);
    lit("nop16_pc",       o_pc[118],  1);
    lit("end_idle",       o_state[125], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
